// File: rtl/gf2m_digit_mul_if.sv
// gf2m_digit_mul_if
//   Request/response bundle between the ECC point-arithmetic sequencer
//   (master) and the digit-serial GF(2^M) multiplier (slave).
//   start      : master -> slave, request a multiply (taken only when idle)
//   abort      : master -> slave, cancel a running multiply
//   a_in, b_in : master -> slave, operands, polynomial basis (bit i = x^i)
//   busy       : slave -> master, operation in progress
//   done       : slave -> master, one-cycle pulse, result_out valid
//   result_out : slave -> master, A*B mod f, held until the next accepted start
interface gf2m_digit_mul_if #(
  parameter int M = 163
) ();
  logic         start;
  logic         abort;
  logic [M-1:0] a_in;
  logic [M-1:0] b_in;
  logic         busy;
  logic         done;
  logic [M-1:0] result_out;

  modport master (
    output start, abort, a_in, b_in,
    input  busy, done, result_out
  );

  modport slave (
    input  start, abort, a_in, b_in,
    output busy, done, result_out
  );
endinterface

// File: rtl/gf2m_digit_mul.sv
// gf2m_digit_mul
//   Digit-serial GF(2^M) multiplier, C = A*B mod f(x), f(x) = x^M + POLY.
//   One D-bit digit of A is consumed per cycle, most significant digit first,
//   so a multiply takes N = ceil(M/D) compute cycles plus one finish cycle.
//   Ports:
//     clk  : clock, rising edge
//     rstn : asynchronous active-low reset
//     bus  : gf2m_digit_mul_if slave (start/abort/a_in/b_in in,
//            busy/done/result_out out)
//   M must be at least 2; POLY bit 0 must be set.
module gf2m_digit_mul #(
  parameter int           M    = 163,
  parameter int           D    = 8,
  parameter logic [M-1:0] POLY = 163'h0C9
) (
  input  logic              clk,
  input  logic              rstn,
  gf2m_digit_mul_if.slave   bus
);

  localparam int N   = (M + D - 1) / D;
  localparam int NDW = N * D;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t          state_reg;
  logic [M-1:0]    a_reg;
  logic [M-1:0]    b_reg;
  logic [M-1:0]    acc_reg;
  logic [CW-1:0]   cnt_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [M-1:0]    result_reg;

  // Multiply by x and reduce: the bit leaving position M-1 stands for x^M,
  // which is congruent to POLY.
  function automatic logic [M-1:0] mul_x(input logic [M-1:0] v);
    return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
  endfunction

  // Digit selection. A is zero-extended to a whole number of digits so the
  // padded top digit carries zeros when D does not divide M.
  logic [NDW-1:0] a_ext;
  logic [D-1:0]   a_digits [N];
  logic [D-1:0]   digit;

  assign a_ext = NDW'(a_reg);

  for (genvar gi = 0; gi < N; gi++) begin : g_digits
    assign a_digits[gi] = a_ext[gi*D +: D];
  end

  if (N > 1) begin : g_digit_mux
    assign digit = a_digits[cnt_reg];
  end else begin : g_digit_single
    assign digit = a_digits[0];
  end

  // acc_sh[j] = acc * x^j mod f, b_sh[j] = B * x^j mod f,
  // pp[j]     = sum over i<j of digit[i] * b_sh[i].
  logic [M-1:0] acc_sh [D+1];
  logic [M-1:0] b_sh   [D];
  logic [M-1:0] pp     [D+1];
  logic [M-1:0] acc_next;

  assign acc_sh[0] = acc_reg;
  assign b_sh[0]   = b_reg;
  assign pp[0]     = '0;

  for (genvar gi = 0; gi < D; gi++) begin : g_steps
    assign acc_sh[gi+1] = mul_x(acc_sh[gi]);
    assign pp[gi+1]     = pp[gi] ^ ({M{digit[gi]}} & b_sh[gi]);
    if (gi < D - 1) begin : g_b_step
      assign b_sh[gi+1] = mul_x(b_sh[gi]);
    end
  end

  // Horner step: shift the running sum up one digit, then add this digit's
  // partial product. Both terms are already reduced, so the XOR is too.
  assign acc_next = acc_sh[D] ^ pp[D];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= S_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // abort has no meaning here, so a simultaneous start simply wins.
          if (bus.start) begin
            a_reg     <= bus.a_in;
            b_reg     <= bus.b_in;
            acc_reg   <= '0;
            cnt_reg   <= CW'(N - 1);
            busy_reg  <= 1'b1;
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == '0) begin
              state_reg <= S_FIN;
            end
          end
        end
        S_FIN: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
          // An abort here drops the finished value and leaves the old result.
          if (!bus.abort) begin
            result_reg <= acc_reg;
            done_reg   <= 1'b1;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.result_out = result_reg;

endmodule

// File: tb/tb_gf2m_digit_mul.sv
// tb_gf2m_digit_mul
//   Four multiplier instances (163/8, 8/4, 163/7, 8/8) driven with directed
//   and random operands; results compared with a carry-less multiply followed
//   by polynomial long division.
module tb_gf2m_digit_mul;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  gf2m_digit_mul_if #(.M(163)) if0 ();
  gf2m_digit_mul_if #(.M(8))   if1 ();
  gf2m_digit_mul_if #(.M(163)) if2 ();
  gf2m_digit_mul_if #(.M(8))   if3 ();

  gf2m_digit_mul #(.M(163), .D(8), .POLY(163'h0C9)) u0 (.clk(clk), .rstn(rstn), .bus(if0.slave));
  gf2m_digit_mul #(.M(8),   .D(4), .POLY(8'h1B))    u1 (.clk(clk), .rstn(rstn), .bus(if1.slave));
  gf2m_digit_mul #(.M(163), .D(7), .POLY(163'h0C9)) u2 (.clk(clk), .rstn(rstn), .bus(if2.slave));
  gf2m_digit_mul #(.M(8),   .D(8), .POLY(8'h1B))    u3 (.clk(clk), .rstn(rstn), .bus(if3.slave));

  function automatic int mm(input int inst);
    return (inst == 0 || inst == 2) ? 163 : 8;
  endfunction

  function automatic int nn(input int inst);
    case (inst)
      0:       return 21;
      1:       return 2;
      2:       return 24;
      default: return 1;
    endcase
  endfunction

  function automatic logic [162:0] pp(input int inst);
    return (inst == 0 || inst == 2) ? 163'h0C9 : 163'h1B;
  endfunction

  // Schoolbook carry-less product, then reduce from the top bit down.
  function automatic logic [162:0] ref_mul(input logic [162:0] a, input logic [162:0] b,
                                           input int m, input logic [162:0] poly);
    logic [325:0] p;
    logic [325:0] f;
    p = '0;
    f = {163'b0, poly} | (326'b1 << m);
    for (int i = 0; i < m; i++)
      if (b[i]) p = p ^ ({163'b0, a} << i);
    for (int i = 2 * m - 2; i >= m; i--)
      if (p[i]) p = p ^ (f << (i - m));
    return p[162:0];
  endfunction

  function automatic logic [162:0] rnd(input int m);
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[162:0] & ((163'd1 << m) - 163'd1);
  endfunction

  task automatic check(input string tag, input logic [162:0] got, input logic [162:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_ctl(input int inst, input logic s, input logic ab);
    case (inst)
      0:       begin if0.start = s; if0.abort = ab; end
      1:       begin if1.start = s; if1.abort = ab; end
      2:       begin if2.start = s; if2.abort = ab; end
      default: begin if3.start = s; if3.abort = ab; end
    endcase
  endtask

  task automatic set_ops(input int inst, input logic [162:0] a, input logic [162:0] b);
    case (inst)
      0:       begin if0.a_in = a;      if0.b_in = b;      end
      1:       begin if1.a_in = a[7:0]; if1.b_in = b[7:0]; end
      2:       begin if2.a_in = a;      if2.b_in = b;      end
      default: begin if3.a_in = a[7:0]; if3.b_in = b[7:0]; end
    endcase
  endtask

  task automatic smp(input int inst, output logic bz, output logic dn, output logic [162:0] r);
    case (inst)
      0:       begin bz = if0.busy; dn = if0.done; r = if0.result_out; end
      1:       begin bz = if1.busy; dn = if1.done; r = 163'(if1.result_out); end
      2:       begin bz = if2.busy; dn = if2.done; r = if2.result_out; end
      default: begin bz = if3.busy; dn = if3.done; r = 163'(if3.result_out); end
    endcase
  endtask

  // Called and returning on a falling edge. Without abort it returns in the
  // done cycle, so an immediately following call is a back-to-back start.
  task automatic run_op(input int inst, input logic [162:0] a, input logic [162:0] b,
                        input int intr_t, input int abort_t, input bit abort_w_start,
                        output time t_done);
    int n, busy_cnt, done_cnt, done_t;
    logic bz, dn, bz_after_abort;
    logic [162:0] r, prev, exp, res_at_done;
    n = nn(inst);
    busy_cnt = 0; done_cnt = 0; done_t = -1; t_done = 0;
    res_at_done = '0; bz_after_abort = 1'b1;
    smp(inst, bz, dn, prev);
    exp = ref_mul(a, b, mm(inst), pp(inst));
    set_ops(inst, a, b);
    set_ctl(inst, 1'b1, abort_w_start);
    @(negedge clk);
    set_ctl(inst, 1'b0, 1'b0);
    set_ops(inst, rnd(mm(inst)), rnd(mm(inst)));
    for (int t = 0; t < n + 6; t++) begin
      smp(inst, bz, dn, r);
      if (bz) busy_cnt++;
      if (dn) begin done_cnt++; done_t = t; t_done = $time; res_at_done = r; end
      if (abort_t >= 0 && t == abort_t + 1) bz_after_abort = bz;
      if (dn && abort_t < 0) break;
      if (intr_t >= 0 && t == intr_t) begin
        set_ops(inst, rnd(mm(inst)), rnd(mm(inst)));
        set_ctl(inst, 1'b1, 1'b0);
      end else if (intr_t >= 0 && t == intr_t + 1) begin
        set_ctl(inst, 1'b0, 1'b0);
      end
      if (abort_t >= 0 && t == abort_t) set_ctl(inst, 1'b0, 1'b1);
      else if (abort_t >= 0 && t == abort_t + 1) set_ctl(inst, 1'b0, 1'b0);
      @(negedge clk);
    end
    if (abort_t < 0) begin
      check("latency", 163'(done_t), 163'(n + 1));
      check("busy_cycles", 163'(busy_cnt), 163'(n + 1));
      check("result", res_at_done, exp);
      $display("op inst=%0d a=%h b=%h res=%h exp=%h lat=%0d", inst, a, b, res_at_done, exp, done_t);
    end else begin
      check("abort_busy", {162'b0, bz_after_abort}, 163'd0);
      check("abort_no_done", 163'(done_cnt), 163'd0);
      check("abort_held", r, prev);
      $display("op inst=%0d aborted at cycle %0d res=%h", inst, abort_t, r);
    end
  endtask

  initial begin
    time td, td0, td1, td2;
    logic bz, dn;
    logic [162:0] r;

    for (int i = 0; i < 4; i++) begin
      set_ctl(i, 1'b0, 1'b0);
      set_ops(i, '0, '0);
    end
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      smp(i, bz, dn, r);
      check("reset_busy", {162'b0, bz}, 163'd0);
      check("reset_done", {162'b0, dn}, 163'd0);
      check("reset_result", r, 163'd0);
    end
    rstn = 1'b1;
    @(negedge clk);

    // Default field: identity, then x^162 * x wrapping into POLY.
    run_op(0, 163'd1, 163'd1, -1, -1, 1'b0, td);
    @(negedge clk);
    smp(0, bz, dn, r);
    check("done_one_cycle", {162'b0, dn}, 163'd0);
    check("one_times_one", r, 163'd1);
    run_op(0, 163'd1 << 162, 163'd2, -1, -1, 1'b0, td);
    smp(0, bz, dn, r);
    check("x162_times_x", r, 163'h0C9);
    for (int i = 0; i < 20; i++) run_op(0, rnd(163), rnd(163), -1, -1, 1'b0, td);

    // start during RUN ignored; abort mid-run; recovery; abort+start in IDLE.
    run_op(0, rnd(163), rnd(163), 5, -1, 1'b0, td);
    run_op(0, rnd(163), rnd(163), -1, 10, 1'b0, td);
    run_op(0, rnd(163), rnd(163), -1, -1, 1'b0, td);
    run_op(0, rnd(163), rnd(163), -1, -1, 1'b1, td);

    // Three back-to-back operations, each started in the previous done cycle.
    run_op(0, rnd(163), rnd(163), -1, -1, 1'b0, td0);
    run_op(0, rnd(163), rnd(163), -1, -1, 1'b0, td1);
    run_op(0, rnd(163), rnd(163), -1, -1, 1'b0, td2);
    check("b2b_spacing_1", 163'(td1 - td0), 163'((nn(0) + 2) * 10));
    check("b2b_spacing_2", 163'(td2 - td1), 163'((nn(0) + 2) * 10));

    // Small field, AES polynomial.
    run_op(1, 163'h57, 163'h83, -1, -1, 1'b0, td);
    smp(1, bz, dn, r);
    check("aes_57_83", r, 163'hC1);
    run_op(1, 163'h00, 163'hFF, -1, -1, 1'b0, td);
    smp(1, bz, dn, r);
    check("zero_times_ff", r, 163'h00);
    for (int i = 0; i < 50; i++) run_op(1, rnd(8), rnd(8), -1, -1, 1'b0, td);

    // Padded top digit (D=7).
    run_op(2, {163{1'b1}}, {163{1'b1}}, -1, -1, 1'b0, td);
    for (int i = 0; i < 1000; i++) run_op(2, rnd(163), rnd(163), -1, -1, 1'b0, td);

    // D = M, single compute cycle.
    for (int i = 0; i < 20; i++) run_op(3, rnd(8), rnd(8), -1, -1, 1'b0, td);

    // Asynchronous reset in the middle of a run.
    set_ops(0, rnd(163), rnd(163));
    set_ctl(0, 1'b1, 1'b0);
    @(negedge clk);
    set_ctl(0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    smp(0, bz, dn, r);
    check("busy_before_reset", {162'b0, bz}, 163'd1);
    rstn = 1'b0;
    #1;
    smp(0, bz, dn, r);
    check("async_reset_busy", {162'b0, bz}, 163'd0);
    check("async_reset_done", {162'b0, dn}, 163'd0);
    check("async_reset_result", r, 163'd0);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    smp(0, bz, dn, r);
    check("after_reset_idle", {162'b0, bz}, 163'd0);
    run_op(0, rnd(163), rnd(163), -1, -1, 1'b0, td);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
